// File: rtl/sorted_block_merger.sv
// Buffers two sorted N-word blocks, then streams their stable two-pointer merge (2N words).
// Latency: first word 1 cycle after the second block is accepted; out_valid/out_data hold under out_ready=0.
module sorted_block_merger #(
  parameter int W = 32,
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W*N-1:0] blk_data,
  input  logic           blk_valid,
  output logic           blk_ready,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_last
);

  localparam int LW = $clog2(N);
  localparam int PW = LW + 1;
  localparam int CW = $clog2(2 * N);

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    MERGE
  } state_t;

  state_t               state;
  logic [N-1:0][W-1:0]  bufa;
  logic [N-1:0][W-1:0]  bufb;
  logic [N-1:0][W-1:0]  blk_lanes;
  logic [PW-1:0]        ia;
  logic [PW-1:0]        ib;
  logic [CW-1:0]        cnt;

  logic [W-1:0]  cur_a;
  logic [W-1:0]  cur_b;
  logic          take_a;
  logic [PW-1:0] na;
  logic [PW-1:0] nb;
  logic [W-1:0]  nxt_a;
  logic [W-1:0]  nxt_b;
  logic [W-1:0]  nxt_word;
  logic [W-1:0]  first_word;
  logic [CW-1:0] cnt_nxt;

  assign blk_lanes = blk_data;

  // An exhausted side never wins; ties go to A so the merge is stable.
  function automatic logic pick_a(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                  input logic [W-1:0] wa, input logic [W-1:0] wb);
    if (a == PW'(N)) return 1'b0;
    if (b == PW'(N)) return 1'b1;
    return wa <= wb;
  endfunction

  // out_data is registered, so the word after the current one is looked up ahead of the handshake.
  always_comb begin
    cur_a      = bufa[ia[LW-1:0]];
    cur_b      = bufb[ib[LW-1:0]];
    take_a     = pick_a(ia, ib, cur_a, cur_b);
    na         = ia + PW'(take_a);
    nb         = ib + PW'(!take_a);
    nxt_a      = bufa[na[LW-1:0]];
    nxt_b      = bufb[nb[LW-1:0]];
    nxt_word   = pick_a(na, nb, nxt_a, nxt_b) ? nxt_a : nxt_b;
    first_word = (bufa[0] <= blk_lanes[0]) ? bufa[0] : blk_lanes[0];
    cnt_nxt    = cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD_A;
      ia        <= '0;
      ib        <= '0;
      cnt       <= '0;
      blk_ready <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        LOAD_A: begin
          if (blk_valid && blk_ready) begin
            bufa  <= blk_lanes;
            state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (blk_valid && blk_ready) begin
            bufb      <= blk_lanes;
            ia        <= '0;
            ib        <= '0;
            cnt       <= '0;
            state     <= MERGE;
            blk_ready <= 1'b0;
            out_valid <= 1'b1;
            out_data  <= first_word;
            out_last  <= 1'b0;
          end
        end
        MERGE: begin
          if (out_valid && out_ready) begin
            ia  <= na;
            ib  <= nb;
            cnt <= cnt_nxt;
            if (out_last) begin
              state     <= LOAD_A;
              blk_ready <= 1'b1;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
            end else begin
              out_data <= nxt_word;
              out_last <= (cnt_nxt == CW'(2 * N - 1));
            end
          end
        end
        default: state <= LOAD_A;
      endcase
    end
  end

endmodule

// File: tb/tb_sorted_block_merger.sv
// Randomized scoreboard bench for sorted_block_merger against a queue-based stable merge model.
module tb_sorted_block_merger;

  localparam int W = 32;
  localparam int N = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W*N-1:0] blk_data = '0;
  logic           blk_valid = 1'b0;
  logic           blk_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic           out_last;

  sorted_block_merger #(.W(W), .N(N)) dut (
    .clk(clk), .rst(rst), .blk_data(blk_data), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   words_seen = 0;
  bit   started = 0;
  bit   rand_mode = 0;
  bit   hold_rdy = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference: stable merge of two queues, A wins ties.
  task automatic model(input logic [W-1:0] a[$], input logic [W-1:0] b[$]);
    logic [W-1:0] m[$];
    exp_t e;
    while (a.size() > 0 && b.size() > 0) begin
      if (a[0] <= b[0]) m.push_back(a.pop_front());
      else m.push_back(b.pop_front());
    end
    while (a.size() > 0) m.push_back(a.pop_front());
    while (b.size() > 0) m.push_back(b.pop_front());
    for (int i = 0; i < m.size(); i++) begin
      e.d = m[i];
      e.l = (i == m.size() - 1);
      exp_q.push_back(e);
    end
  endtask

  function automatic logic [W*N-1:0] pack(input logic [W-1:0] q[$]);
    logic [W*N-1:0] r = '0;
    for (int i = 0; i < N; i++) r[i*W +: W] = q[i];
    return r;
  endfunction

  task automatic gen_sorted(input logic [31:0] maxv, output logic [W-1:0] q[$]);
    q = {};
    repeat (N) q.push_back($urandom_range(maxv, 0));
    q.sort();
  endtask

  task automatic send_block(input logic [W*N-1:0] d, input bit is_b);
    int n = 0;
    @(posedge clk); #2;
    blk_data  = d;
    blk_valid = 1'b1;
    @(negedge clk);
    while (blk_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      n_checks++;
      $display("FAIL blk_accept_timeout: blk_ready stuck at %b", blk_ready);
    end
    @(posedge clk); #2;
    blk_valid = 1'b0;
    if (is_b) begin
      @(negedge clk);
      chk("first_valid_after_b", 32'(out_valid), 32'd1);
      chk("blk_ready_low_after_b", 32'(blk_ready), 32'd0);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d words outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_pair(input logic [W-1:0] a[$], input logic [W-1:0] b[$], input bit wait_done);
    model(a, b);
    words_seen = 0;
    send_block(pack(a), 1'b0);
    send_block(pack(b), 1'b1);
    if (wait_done) drain();
  endtask

  // Sink readiness, randomized when rand_mode is set.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!hold_rdy) out_ready = rand_mode ? 1'($urandom_range(1, 0)) : 1'b1;
    end
  end

  // Monitor: scoreboard pop, hold-under-stall, idle zeros, no loading during merge.
  initial begin
    bit           prev_stall = 0;
    logic [W-1:0] prev_data = '0;
    logic         prev_last = 1'b0;
    exp_t         e;
    forever begin
      @(negedge clk);
      if (started) begin
        if (out_valid === 1'b1) begin
          chk("blk_ready_in_merge", 32'(blk_ready), 32'd0);
          if (prev_stall) begin
            chk("stall_data_hold", out_data, prev_data);
            chk("stall_last_hold", 32'(out_last), 32'(prev_last));
          end
          if (out_ready) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              $display("FAIL unexpected_word: got %h expected none", out_data);
            end else begin
              e = exp_q.pop_front();
              chk("out_data", out_data, e.d);
              chk("out_last", 32'(out_last), 32'(e.l));
            end
            words_seen++;
          end
          prev_stall = !out_ready;
          prev_data  = out_data;
          prev_last  = out_last;
        end else if (out_valid === 1'b0) begin
          chk("idle_data_zero", out_data, 32'd0);
          chk("idle_last_zero", 32'(out_last), 32'd0);
          prev_stall = 0;
        end else begin
          chk("out_valid_known", 32'(out_valid), 32'd0);
        end
      end
    end
  end

  initial begin
    logic [W-1:0] a[$];
    logic [W-1:0] b[$];
    int n;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_blk_ready", 32'(blk_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    started = 1;

    // Disjoint ranges, then interleaved evens/odds.
    a = {}; b = {};
    for (int i = 0; i < N; i++) begin a.push_back(i); b.push_back(i + N); end
    run_pair(a, b, 1'b1);
    a = {}; b = {};
    for (int i = 0; i < N; i++) begin a.push_back(2 * i); b.push_back(2 * i + 1); end
    run_pair(a, b, 1'b1);

    // Equal keys, plain and with B tagged in the top bit.
    a = {}; b = {};
    for (int i = 0; i < N; i++) begin a.push_back(7); b.push_back(7); end
    run_pair(a, b, 1'b1);
    a = {}; b = {};
    for (int i = 0; i < N; i++) begin a.push_back(32'h0000_0007); b.push_back(32'h8000_0007); end
    run_pair(a, b, 1'b1);

    // Unsigned extremes: all of B must come out first.
    a = {}; b = {};
    for (int i = 0; i < N; i++) begin a.push_back(32'hFFFF_FFFF); b.push_back(32'h0); end
    run_pair(a, b, 1'b1);

    // Random sorted blocks under random backpressure; small ranges force ties.
    rand_mode = 1;
    for (int t = 0; t < 8; t++) begin
      gen_sorted((t % 2 == 0) ? 32'd20 : 32'hFFFF_FFFF, a);
      gen_sorted((t % 2 == 0) ? 32'd20 : 32'hFFFF_FFFF, b);
      run_pair(a, b, 1'b1);
    end

    // Reset after 10 words, then a fresh pair from word 0.
    rand_mode = 0;
    gen_sorted(32'd1000, a);
    gen_sorted(32'd1000, b);
    run_pair(a, b, 1'b0);
    n = 0;
    while (words_seen < 10 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (words_seen < 10) begin
      n_checks++;
      $display("FAIL reset_wait_timeout: %0d words seen, expected 10", words_seen);
    end
    @(posedge clk); #2;
    hold_rdy  = 1;
    out_ready = 1'b0;
    rst       = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_blk_ready", 32'(blk_ready), 32'd1);
    hold_rdy = 0;
    rand_mode = 1;
    gen_sorted(32'd50, a);
    gen_sorted(32'd50, b);
    run_pair(a, b, 1'b1);

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
